// File: rtl/mips_avalon_bus_unit.sv
// mips_avalon_bus_unit: arbitrates fetch and load/store requests onto one Avalon-MM master with lane steering, misalign trap and timeout.
module mips_avalon_bus_unit #(
  parameter int ADDR_W = 32,
  parameter bit FETCH_PRIORITY = 1'b0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              data_req,
  output logic              data_ready,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_signed,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_done,
  output logic [31:0]       data_rdata,
  output logic              data_err,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, TRAP} state_t;
  state_t state;
  logic [31:0] cnt;
  logic [1:0] lo, sz;
  logic sgn, we;
  logic idle, fa, da, fmis, dmis, tmo, fin;
  logic [3:0] dbe;
  logic [31:0] dwd, ld;
  logic [15:0] lane;
  always_comb begin
    idle = state == IDLE;
    fetch_ready = idle && (FETCH_PRIORITY || !data_req);
    data_ready = idle && (!FETCH_PRIORITY || !fetch_req);
    busy = !idle;
    fa = fetch_req && fetch_ready;
    da = data_req && data_ready;
    fmis = fetch_addr[1:0] != 2'b00;
    dmis = (data_size == 2'b11) || (data_size == 2'b01 && data_addr[0]) ||
           (data_size == 2'b10 && data_addr[1:0] != 2'b00);
    dbe = data_size == 2'b00 ? 4'b0001 << data_addr[1:0] :
          data_size == 2'b01 ? (data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dwd = data_size == 2'b00 ? {4{data_wdata[7:0]}} :
          data_size == 2'b01 ? {2{data_wdata[15:0]}} : data_wdata;
    lane = 16'(readdata >> {lo, 3'b000});
    ld = sz == 2'b00 ? {{24{sgn & lane[7]}}, lane[7:0]} :
         sz == 2'b01 ? {{16{sgn & lane[15]}}, lane} : readdata;
    tmo = TIMEOUT_CYCLES != 0 && waitrequest && cnt == 32'(TIMEOUT_CYCLES - 1);
    fin = !waitrequest || tmo;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      read <= 1'b0;
      write <= 1'b0;
      fetch_done <= 1'b0;
      data_done <= 1'b0;
      fetch_err <= 1'b0;
      data_err <= 1'b0;
      address <= '0;
      writedata <= 32'd0;
      byteenable <= 4'b0000;
      fetch_data <= 32'd0;
      data_rdata <= 32'd0;
      cnt <= 32'd0;
      lo <= 2'b00;
      sz <= 2'b00;
      sgn <= 1'b0;
      we <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      data_done <= 1'b0;
      fetch_err <= 1'b0;
      data_err <= 1'b0;
      case (state)
        IDLE: if (fa || da) begin
          cnt <= 32'd0;
          lo <= data_addr[1:0];
          sz <= data_size;
          sgn <= data_signed;
          we <= data_we;
          // a trapped request reports immediately; the TRAP state just holds busy
          if (fa ? fmis : dmis) begin
            state <= TRAP;
            fetch_done <= fa;
            fetch_err <= fa;
            data_done <= !fa;
            data_err <= !fa;
          end else begin
            state <= fa ? FETCH : DATA;
            read <= fa || !data_we;
            write <= !fa && data_we;
            address <= fa ? {fetch_addr[ADDR_W-1:2], 2'b00} : {data_addr[ADDR_W-1:2], 2'b00};
            byteenable <= fa ? 4'b1111 : dbe;
            if (!fa) writedata <= dwd;
          end
        end
        FETCH, DATA: if (fin) begin
          state <= IDLE;
          read <= 1'b0;
          write <= 1'b0;
          if (state == FETCH) begin
            fetch_done <= 1'b1;
            fetch_err <= tmo;
            fetch_data <= tmo ? 32'd0 : readdata;
          end else begin
            data_done <= 1'b1;
            data_err <= tmo;
            if (tmo || !we) data_rdata <= tmo ? 32'd0 : ld;
          end
        end else cnt <= cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_avalon_bus_unit.sv
// tb_mips_avalon_bus_unit: directed and randomized accesses checked against an arithmetic model of the bus unit.
module tb_mips_avalon_bus_unit;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic reset;
  logic fetch_req, fetch_ready, fetch_done, fetch_err;
  logic [31:0] fetch_addr, fetch_data;
  logic data_req, data_ready, data_we, data_signed, data_done, data_err;
  logic [1:0] data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic busy, read, write, waitrequest;
  logic [31:0] address, writedata, readdata;
  logic [3:0] byteenable;
  int checks = 0, failures = 0;
  logic [31:0] m_fdata, m_rdata;

  always #5 clk = ~clk;

  mips_avalon_bus_unit #(.ADDR_W(32), .FETCH_PRIORITY(1'b0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .data_req(data_req), .data_ready(data_ready), .data_we(data_we), .data_size(data_size),
    .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata), .data_err(data_err),
    .busy(busy), .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input bit f, input logic [1:0] sz, input logic [31:0] a);
    if (f) return a % 4 != 0;
    return sz == 3 || (sz == 1 && a % 2 == 1) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] exp_be(input bit f, input logic [1:0] sz, input logic [31:0] a);
    if (f || sz == 2) return 4'hF;
    if (sz == 0) return 4'(1 << (a % 4));
    return (a % 4 >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 0) return (w % 256) * 32'h01010101;
    if (sz == 1) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit sgn, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, m;
    if (sz == 2) return rd;
    m = (sz == 0) ? 32'd256 : 32'd65536;
    v = (rd >> (8 * (a % 4))) % m;
    if (sgn && v >= m / 2) v = v - m;
    return v;
  endfunction

  task automatic chk_reset(input string t);
    chk({t, "_rw_busy"}, {read, write, busy}, 0);
    chk({t, "_done_err"}, {fetch_done, data_done, fetch_err, data_err}, 0);
    chk({t, "_address"}, address, 0);
    chk({t, "_writedata"}, writedata, 0);
    chk({t, "_byteenable"}, byteenable, 0);
    chk({t, "_fetch_data"}, fetch_data, 0);
    chk({t, "_data_rdata"}, data_rdata, 0);
  endtask

  // Starts at a negedge with the unit idle; ends in the done cycle (or the idle cycle after a trap).
  task automatic access(input bit f, input bit we, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd, input int waits);
    bit mis, to, wr;
    int n;
    mis = misal(f, sz, a);
    to = waits >= TMO;
    n = to ? TMO : waits + 1;
    wr = !f && we;
    if (f) begin
      fetch_req = 1'b1; fetch_addr = a;
    end else begin
      data_req = 1'b1; data_we = we; data_size = sz; data_signed = sgn; data_addr = a; data_wdata = w;
    end
    #1;
    chk(f ? "fetch_ready" : "data_ready", f ? fetch_ready : data_ready, 1);
    @(negedge clk);
    if (f) begin
      fetch_req = 1'b0; fetch_addr = $urandom;
    end else begin
      data_req = 1'b0; data_we = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 3));
      data_signed = 1'($urandom_range(0, 1)); data_addr = $urandom; data_wdata = $urandom;
    end
    if (mis) begin
      chk("trap_rw", {read, write}, 0);
      chk("trap_busy", busy, 1);
      chk("trap_done_err", {fetch_done, fetch_err, data_done, data_err}, f ? 4'b1100 : 4'b0011);
      chk("trap_fetch_data", fetch_data, m_fdata);
      chk("trap_data_rdata", data_rdata, m_rdata);
      @(negedge clk);
      chk("trap_end", {busy, fetch_done, data_done}, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      chk("read", read, !wr);
      chk("write", write, wr);
      chk("address", address, a & ~32'd3);
      chk("byteenable", byteenable, exp_be(f, sz, a));
      if (wr) chk("writedata", writedata, exp_wd(sz, w));
      chk("done_low", {fetch_done, data_done}, 0);
      waitrequest = (i < waits);
      readdata = (i < waits) ? $urandom : rd;
      @(negedge clk);
    end
    waitrequest = 1'b0;
    readdata = $urandom;
    if (to) begin
      if (f) m_fdata = 0; else m_rdata = 0;
    end else if (f) m_fdata = rd;
    else if (!wr) m_rdata = exp_load(sz, sgn, a, rd);
    chk("rw_dropped", {read, write}, 0);
    chk("done", f ? fetch_done : data_done, 1);
    chk("other_done", f ? data_done : fetch_done, 0);
    chk("err", f ? fetch_err : data_err, to);
    chk("fetch_data", fetch_data, m_fdata);
    chk("data_rdata", data_rdata, m_rdata);
  endtask

  initial begin
    bit f, we, sgn;
    logic [1:0] sz;
    logic [31:0] a;
    int waits;
    reset = 1'b1;
    fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0; data_size = 0; data_signed = 0;
    data_addr = 0; data_wdata = 0; waitrequest = 0; readdata = 0;
    m_fdata = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    @(negedge clk);
    access(1, 0, 2, 0, 32'h100, 0, 32'h2402000A, 0);
    // simultaneous requests: data wins, fetch waits
    fetch_req = 1'b1; fetch_addr = 32'h500; data_req = 1'b1;
    #1;
    chk("fetch_ready_loses", fetch_ready, 0);
    access(0, 0, 2, 0, 32'h504, 0, 32'h11223344, 1);
    chk("fetch_ready_after_data", fetch_ready, 1);
    access(1, 0, 2, 0, 32'h500, 0, 32'hCAFEF00D, 0);
    access(0, 0, 0, 1, 32'h203, 0, 32'h80FFFFFF, 0);
    access(0, 0, 0, 0, 32'h203, 0, 32'h80FFFFFF, 0);
    access(0, 1, 1, 0, 32'h302, 32'h1234ABCD, 0, 3);
    access(0, 0, 1, 1, 32'h302, 0, 32'h9ABC0000, 2);
    access(0, 0, 2, 0, 32'h401, 0, 0, 0);
    access(1, 0, 2, 0, 32'h102, 0, 0, 0);
    access(0, 0, 3, 0, 32'h400, 0, 0, 0);
    access(0, 0, 2, 1, 32'h700, 0, 32'hDEADBEEF, TMO);
    access(1, 0, 2, 0, 32'h800, 0, 32'h12345678, TMO + 2);
    for (int k = 0; k < 40; k++) begin
      f = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = (f || sz == 2) ? a & ~32'd3 : (sz == 1) ? a & ~32'd1 : a;
      waits = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
      access(f, we, sz, sgn, a, $urandom, $urandom, waits);
    end
    @(negedge clk);
    chk("final_done_low", {fetch_done, data_done, busy}, 0);
    // reset during a stalled transfer
    data_req = 1'b1; data_we = 1'b0; data_size = 2'd2; data_addr = 32'h600; waitrequest = 1'b1;
    @(negedge clk);
    data_req = 1'b0;
    chk("mid_read", read, 1);
    @(negedge clk);
    chk("mid_read_held", read, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("mid_reset");
    m_fdata = 0; m_rdata = 0;
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    chk("post_reset_quiet", {fetch_done, data_done, busy, read}, 0);
    @(negedge clk);
    chk("post_reset_quiet2", {fetch_done, data_done, busy, read}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
